pattern_ram_sp: RTL and testbench
=================================

Name: pattern_ram_sp

Overview:
- Single-port synchronous pattern memory, 256 x 8 by default.
- Stores the serial-output bit patterns that the pattern sequencer fetches; one address bus serves both reads and writes.
- Behaviour matches a vendor single-port block RAM: registered address/data/write-enable, one-cycle read latency, write-through on read-during-write.
- Adds an active-low asynchronous reset for the output path and, optionally, a post-reset memory clear sweep.

Parameters:
- ADDR_WIDTH, 8, address bus width.
- DATA_WIDTH, 8, word width.
- DEPTH, 2**ADDR_WIDTH, number of words; must be at most 2**ADDR_WIDTH.
- INIT_VALUE, 0, word written by the clear sweep (optional feature only).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- address  in  ADDR_WIDTH  word address for read and write.
- data  in  DATA_WIDTH  write data.
- wren  in  1  write enable, active high.
- q  out  DATA_WIDTH  read data.
- init_busy  out  1  high while the clear sweep runs; tied 0 when the feature is compiled out.

Behaviour:
- Input registration: address, data and wren are sampled on every rising clock edge.
- Write: if wren=1 at the edge, mem[address] <= data.
- Read latency: q shows mem[address] as sampled at the previous edge, so a read issued at edge N is valid after edge N and stable until edge N+1.
- Read-during-write: when wren=1, q after that edge equals the data just written (new data).
- Address range: addresses >= DEPTH are ignored on write, and q reads 0 for them.
- Reset assertion:
  - q goes to 0 immediately, asynchronously.
  - The internal address register clears to 0.
  - Memory contents are not altered by the reset assertion itself.
- While rst_n=0:
  - writes are blocked;
  - q holds 0.
- First read after reset release: the first edge with rst_n=1 resumes normal operation, so q then shows mem[address] sampled at that edge.
- Simultaneous events: there is only one port, so no collision other than read-during-write, which is covered above.
- No handshake; the block accepts one access per cycle, every cycle.

Optional Feature:
- Macro: PATTERN_RAM_CLEAR_EN.
- Defined:
  - On rst_n deassertion, an internal counter sweeps addresses 0..DEPTH-1, writing INIT_VALUE once per cycle.
  - init_busy=1 from reset until the cycle after the last word is written, i.e. DEPTH cycles after the first edge out of reset.
  - During the sweep, user wren is ignored and q holds 0.
  - init_busy resets to 1 asynchronously, so a reset mid-sweep restarts the sweep from address 0.
  - After the sweep, every word reads INIT_VALUE.
- Not defined:
  - No sweep; init_busy is constant 0.
  - Initial memory contents are undefined (X in simulation).
  - Contents survive resets.

Test Plan:
- Reset with rst_n=0, address=5 -> q=0 immediately, at no clock edge; init_busy=1 if PATTERN_RAM_CLEAR_EN is defined, else 0.
- Write loop: wren=1, address=i, data=i for i=0..4 on consecutive edges -> q equals i after each write edge (write-through).
- Readback: wren=0, address=0..4 on consecutive edges -> after each edge q is 0,1,2,3,4, one-cycle latency.
- Overwrite and reset: write 0xA5 to address 3, pulse rst_n low mid-idle, then read address 3 -> q=0 during reset; 0xA5 after the first read edge post-reset (CLEAR_EN undefined).
- Clear sweep (PATTERN_RAM_CLEAR_EN, INIT_VALUE=8'h3C): write 0xFF to address 7 before reset, reset, wait until init_busy falls (256 cycles) -> addresses 0, 7 and 255 all read 0x3C; a write attempted during the sweep is not retained.
- Reset mid-sweep at cycle 100 -> init_busy stays 1, the sweep restarts from 0, and init_busy falls 256 cycles after release.

Source files
------------

// File: rtl/pattern_ram_sp.sv
// Single-port pattern RAM: registered inputs, one-cycle read, write-through, async-reset output path.
// Optional post-reset clear sweep under PATTERN_RAM_CLEAR_EN (writes INIT_VALUE to every word).
module pattern_ram_sp #(
  parameter int                     ADDR_WIDTH = 8,
  parameter int                     DATA_WIDTH = 8,
  parameter int                     DEPTH      = 2 ** ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  init_busy
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  in_range;
  logic                  busy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_dat;

  assign in_range = ({1'b0, address} < DEPTH_W);

`ifdef PATTERN_RAM_CLEAR_EN
  logic [ADDR_WIDTH-1:0] sweep_addr;

  // busy comes up set so any reset, including one mid-sweep, restarts from word 0
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b1;
      sweep_addr <= '0;
    end else if (busy) begin
      if (sweep_addr == LAST) busy <= 1'b0;
      else                    sweep_addr <= sweep_addr + 1'b1;
    end
  end

  always_comb begin
    wr_en   = wren & in_range;
    wr_addr = address;
    wr_dat  = data;
    if (busy) begin
      wr_en   = 1'b1;
      wr_addr = sweep_addr;
      wr_dat  = INIT_VALUE;
    end
  end
`else
  logic unused_init;

  assign unused_init = ^INIT_VALUE;
  assign busy        = 1'b0;
  assign wr_en       = wren & in_range;
  assign wr_addr     = address;
  assign wr_dat      = data;
`endif

  assign init_busy = busy;

  // Contents are kept across reset; reset only blocks the write.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
    end else if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                q <= '0;
    else if (busy || !in_range) q <= '0;
    else if (wren)             q <= data;
    else                       q <= mem[address];
  end

endmodule

// File: tb/tb_pattern_ram_sp.sv
// Randomized self-checking bench for pattern_ram_sp against a word-array reference model.
module tb_pattern_ram_sp;

  localparam int          AW    = 8;
  localparam int          DW    = 8;
  localparam int          DEPTH = 256;
  localparam logic [7:0]  INITV = 8'h3C;
`ifdef PATTERN_RAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clock;
  logic          rst_n;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          wren;
  logic [DW-1:0] q;
  logic          init_busy;

  pattern_ram_sp #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .INIT_VALUE (INITV)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .address   (address),
    .data      (data),
    .wren      (wren),
    .q         (q),
    .init_busy (init_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] ref_mem [DEPTH];
  bit         known   [DEPTH];
  int         sweep_left = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock edge of the reference model, then compare q and init_busy.
  task automatic tick(input string tag);
    logic [7:0] exp_q;
    bit         exp_known;
    @(posedge clock);
    exp_q     = 8'h00;
    exp_known = 1'b1;
    if (rst_n) begin
      if (sweep_left > 0) begin
        sweep_left--;
        if (sweep_left == 0)
          for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = INITV;
            known[i]   = 1'b1;
          end
      end else if (wren) begin
        ref_mem[address] = data;
        known[address]   = 1'b1;
        exp_q            = data;
      end else begin
        exp_q     = ref_mem[address];
        exp_known = known[address];
      end
    end
    #1;
    if (exp_known) check(tag, {24'd0, q}, {24'd0, exp_q});
    check({tag, "_busy"}, {31'd0, init_busy}, {31'd0, sweep_left > 0});
  endtask

  task automatic reset_on();
    rst_n = 1'b0;
    if (CLR) sweep_left = DEPTH;
    #1;
    check("rst_q", {24'd0, q}, 32'd0);
    check("rst_busy", {31'd0, init_busy}, {31'd0, CLR});
  endtask

  task automatic wait_sweep(input string tag);
    int n = 0;
    while (init_busy && n < 400) begin
      tick(tag);
      n++;
    end
    check({tag, "_len"}, n, CLR ? DEPTH : 0);
  endtask

  task automatic rd(input int a, input string tag);
    wren    = 1'b0;
    address = AW'(a);
    tick(tag);
  endtask

  task automatic wr(input int a, input logic [7:0] d, input string tag);
    wren    = 1'b1;
    address = AW'(a);
    data    = d;
    tick(tag);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 8'h00;
      known[i]   = 1'b0;
    end
    rst_n   = 1'b1;
    address = 8'd5;
    data    = 8'h00;
    wren    = 1'b0;
    #1;
    reset_on();
    // writes attempted under reset must be blocked
    wr(9, 8'hEE, "rst_wr");
    tick("rst_hold");
    rst_n = 1'b1;
    wait_sweep("sweep0");

    for (int i = 0; i < 5; i++) wr(i, 8'(i), "wr_thru");
    for (int i = 0; i < 5; i++) rd(i, "readback");

    wr(3, 8'hA5, "wr_a5");
    wr(9, 8'h11, "wr_11");
    wren = 1'b0;
    tick("idle");
    #3;
    reset_on();
    wren    = 1'b1;
    address = 8'd9;
    data    = 8'hEE;
    tick("rst_blk");
    rst_n = 1'b1;
    wait_sweep("sweep1");
    rd(3, "post_rst3");
    rd(9, "post_rst9");

    for (int k = 0; k < 300; k++) begin
      wren    = 1'($urandom_range(0, 1));
      address = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      data    = 8'($urandom);
      tick("rand");
    end

    if (CLR) begin
      wr(7, 8'hFF, "wr_ff");
      reset_on();
      tick("rst_c");
      rst_n = 1'b1;
      wr(20, 8'h99, "sweep_wr");
      wait_sweep("sweep2");
      rd(0, "clr0");
      rd(7, "clr7");
      rd(255, "clr255");
      rd(20, "clr20");

      reset_on();
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) rd(i, "mid");
      reset_on();
      tick("mid_rst");
      rst_n = 1'b1;
      wait_sweep("sweep3");
      rd(99, "mid_after");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
